jtcps1_dwnld_ctrl: RTL and testbench
====================================

Name: jtcps1_dwnld_ctrl

Overview:
- Sequences ROM download from the ioctl byte stream into SDRAM.
- Packs bytes into 16-bit words with byte masks and buffers them in a small FIFO.
- Issues SDRAM write requests under a request/acknowledge handshake.
- Also emits the config-register write strobes and signals end of download once all writes are committed.

Parameters:
- REGSIZE, 21: ioctl byte addresses 0..REGSIZE-1 also generate cfg_we strobes.
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW entries of {addr[21:0], data[15:0], mask[1:0]}.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- downloading  in  1  download window active
- ioctl_addr  in  23  byte address
- ioctl_data  in  8  byte data
- ioctl_wr  in  1  byte strobe, single-cycle
- prog_addr  out  22  SDRAM word address
- prog_data  out  16  SDRAM write data
- prog_mask  out  2  byte mask, active low; bit0 = low byte
- prog_we  out  1  write request, held until acknowledged
- prog_rdy  in  1  SDRAM acknowledge, single-cycle pulse
- cfg_we  out  1  config write strobe
- cfg_addr  out  5  config register index
- cfg_data  out  8  config register data
- dwnld_busy  out  1  download or pending writes in progress
- dwnld_done  out  1  single-cycle pulse, all writes committed
- ovf  out  1  sticky FIFO overflow flag

Behaviour:
- Reset values: all outputs 0; FIFO empty; pairing register empty; FSM in IDLE. Reset mid-operation discards all pending data; prog_we falls at the reset edge.
- Bytes are accepted only when ioctl_wr && downloading.
- Byte pairing:
  - Even-address byte: held in the pairing register, with word address ioctl_addr[22:1].
  - Odd byte with the same word address: pushes {held, odd} with data = {odd, even} and mask 2'b00.
  - Unpaired odd byte: pushed alone, data = {byte, 8'h00}, mask 2'b01.
  - Held even byte flushed alone, data = {8'h00, byte}, mask 2'b10, when any of these occurs:
    - a new even byte arrives (the new byte is then held);
    - an odd byte with a different word address arrives (that odd byte follows as its own unpaired push);
    - downloading falls.
  - When two pushes are due in the same cycle, the flush goes first and the second push is taken the following cycle. A one-entry skid register allows this; ioctl strobes are at least 2 cycles apart.
- FIFO:
  - Push while full: entry dropped and ovf set.
  - ovf clears only on rst or on the rising edge of downloading.
  - Simultaneous push and pop on a full FIFO is legal and does not set ovf.
- Write FSM:
  - IDLE: FIFO non-empty -> REQ. Load prog_addr/data/mask from the head and set prog_we.
  - REQ: hold outputs stable until prog_rdy. On prog_rdy, pop the head. If the FIFO is still non-empty, load the next entry and keep prog_we high (back-to-back). Otherwise clear prog_we and go to IDLE.
  - prog_rdy while in IDLE is ignored.
- Latency: word pushed at cycle N into an empty FIFO with the FSM in IDLE -> prog_we high at cycle N+2.
- Config path:
  - Condition: accepted byte with full ioctl_addr < REGSIZE (all 23 bits compared).
  - Response: cfg_we high for 1 cycle at the next edge, with cfg_addr = ioctl_addr[4:0] and cfg_data = ioctl_data.
  - These bytes still go to SDRAM.
- Status:
  - dwnld_busy = downloading | pairing register valid | skid valid | FIFO non-empty | FSM in REQ.
  - dwnld_done pulses 1 cycle on the falling edge of dwnld_busy, only if downloading was high at some point since reset.
- ioctl_wr while downloading is low is ignored entirely.

Optional Feature:
- Macro: JTCPS1_DWNLD_CHKSUM_EN.
- Enabled:
  - Adds output chksum [15:0]: 16-bit wrap-around sum of every accepted byte, including dropped ones.
  - Cleared on rst and on the rising edge of downloading.
  - Updates the cycle after acceptance; stable when dwnld_done pulses.
- Disabled: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Bytes 0x11@0, 0x22@1 with prog_rdy returned 3 cycles after each request -> exactly one write: addr 0, data 0x2211, mask 00, then dwnld_done pulse after downloading falls.
2. Bytes 0xAA@4 then 0xBB@9 -> writes {addr 2, 0x00AA, mask 10} then {addr 4, 0xBB00, mask 01}, in that order.
3. prog_rdy tied low, FIFO_AW=2, 6 full words -> 4 entries held (prog_we high on the first), ovf=1; raise prog_rdy -> 4 writes drained in order, then next downloading rise clears ovf.
4. Bytes at addresses 0..24 -> cfg_we pulses 21 times (addresses 0..20, matching data), none for 21..24; all 13 SDRAM writes still occur.
5. Assert rst while prog_we is high with 3 entries queued -> prog_we=0, dwnld_busy=0, no dwnld_done pulse, no further writes after release.
6. JTCPS1_DWNLD_CHKSUM_EN: bytes 0xFF, 0xFF, 0x03 -> chksum=0x0201; new download rise -> 0x0000.

Source files
------------

// File: rtl/jtcps1_dwnld_ctrl.sv
// jtcps1_dwnld_ctrl
//   Turns the ioctl ROM byte stream into 16-bit SDRAM word writes.
//
//   Byte path:
//   - Accepted bytes (ioctl_wr && downloading) are paired into words.
//   - Each word carries an active-low byte mask.
//   - Words are queued in a small FIFO of 2**FIFO_AW entries.
//
//   Write FSM:
//   - Drains the FIFO through a prog_we / prog_rdy handshake.
//
//   Config path:
//   - Bytes at ioctl_addr < REGSIZE also produce a one-cycle cfg_we strobe.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     downloading         download window
//     ioctl_addr/data/wr  incoming byte stream (23-bit byte address)
//     prog_addr/data/mask SDRAM word address, data, mask (bit0 = low byte)
//     prog_we, prog_rdy   write request held until the one-cycle acknowledge
//     cfg_we/addr/data    config register write strobe
//     dwnld_busy          download or pending writes in flight
//     dwnld_done          one-cycle pulse once every write has committed
//     ovf                 sticky FIFO overflow flag
//     chksum              16-bit sum of accepted bytes
//                         (only with JTCPS1_DWNLD_CHKSUM_EN defined)
//
//   Optional feature macro: JTCPS1_DWNLD_CHKSUM_EN
module jtcps1_dwnld_ctrl #(
  parameter int REGSIZE = 21,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [22:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        cfg_we,
  output logic [4:0]  cfg_addr,
  output logic [7:0]  cfg_data,
  output logic        dwnld_busy,
  output logic        dwnld_done,
  output logic        ovf
`ifdef JTCPS1_DWNLD_CHKSUM_EN
  ,
  output logic [15:0] chksum
`endif
);

  localparam int DEPTH = 2**FIFO_AW;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  logic dl_q;
  logic dl_rise, dl_fall, acc;

  assign dl_rise = downloading & ~dl_q;
  assign dl_fall = ~downloading & dl_q;
  assign acc     = ioctl_wr & downloading;

  // ---------------- byte pairing / skid ----------------
  logic        pr_vld_q, pr_vld_d;
  logic [21:0] pr_addr_q, pr_addr_d;
  logic [7:0]  pr_data_q, pr_data_d;
  logic        sk_vld_q, sk_vld_d;
  entry_t      sk_q, sk_d;
  logic        push;
  entry_t      push_e;
  entry_t      flush_e;
  logic [21:0] byte_waddr;

  assign byte_waddr = ioctl_addr[22:1];
  assign flush_e    = {pr_addr_q, 8'h00, pr_data_q, 2'b10};

  always_comb begin
    pr_vld_d  = pr_vld_q;
    pr_addr_d = pr_addr_q;
    pr_data_d = pr_data_q;
    sk_vld_d  = sk_vld_q;
    sk_d      = sk_q;
    push      = 1'b0;
    push_e    = '0;
    // The skid slot only fills on the cycle of a byte, and strobes are
    // spaced at least two cycles, so it never competes with a new byte.
    if (sk_vld_q) begin
      push     = 1'b1;
      push_e   = sk_q;
      sk_vld_d = 1'b0;
    end else if (acc) begin
      if (!ioctl_addr[0]) begin
        if (pr_vld_q) begin
          push   = 1'b1;
          push_e = flush_e;
        end
        pr_vld_d  = 1'b1;
        pr_addr_d = byte_waddr;
        pr_data_d = ioctl_data;
      end else if (pr_vld_q && (pr_addr_q == byte_waddr)) begin
        push     = 1'b1;
        push_e   = {byte_waddr, ioctl_data, pr_data_q, 2'b00};
        pr_vld_d = 1'b0;
      end else if (pr_vld_q) begin
        // Flush the stranded even byte now, the odd byte goes next cycle.
        push     = 1'b1;
        push_e   = flush_e;
        pr_vld_d = 1'b0;
        sk_vld_d = 1'b1;
        sk_d     = {byte_waddr, ioctl_data, 8'h00, 2'b01};
      end else begin
        push   = 1'b1;
        push_e = {byte_waddr, ioctl_data, 8'h00, 2'b01};
      end
    end else if (dl_fall && pr_vld_q) begin
      push     = 1'b1;
      push_e   = flush_e;
      pr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q      <= 1'b0;
      pr_vld_q  <= 1'b0;
      pr_addr_q <= '0;
      pr_data_q <= '0;
      sk_vld_q  <= 1'b0;
      sk_q      <= '0;
    end else begin
      dl_q      <= downloading;
      pr_vld_q  <= pr_vld_d;
      pr_addr_q <= pr_addr_d;
      pr_data_q <= pr_data_d;
      sk_vld_q  <= sk_vld_d;
      sk_q      <= sk_d;
    end
  end

  // ---------------- FIFO ----------------
  entry_t             mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               full, empty, pop, wr_en;
  logic               ovf_q;
  state_t             state_q;

  assign full  = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  // The head stays in the FIFO while it is being requested.
  assign pop   = (state_q == REQ) & prog_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push & (~full | pop);
  assign cnt_d = cnt_q + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (push && !wr_en) ovf_q <= 1'b1;
      else if (dl_rise)   ovf_q <= 1'b0;
    end
  end

  // ---------------- write FSM ----------------
  entry_t      head, next_e;
  logic [21:0] prog_addr_q;
  logic [15:0] prog_data_q;
  logic [1:0]  prog_mask_q;
  logic        prog_we_q;

  assign head   = mem_q[rd_ptr_q];
  assign next_e = mem_q[rd_ptr_q + FIFO_AW'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            {prog_addr_q, prog_data_q, prog_mask_q} <= head;
            prog_we_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (prog_rdy) begin
            rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            // A word written this very cycle is not yet readable behind the
            // head, so it is picked up from IDLE on the next cycle instead.
            if (cnt_q > (FIFO_AW+1)'(1)) begin
              {prog_addr_q, prog_data_q, prog_mask_q} <= next_e;
            end else begin
              prog_we_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- config strobe and status ----------------
  logic       cfg_we_q;
  logic [4:0] cfg_addr_q;
  logic [7:0] cfg_data_q;
  logic       busy, busy_q, seen_q, done_q;

  assign busy = downloading | pr_vld_q | sk_vld_q | ~empty | (state_q == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_we_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      busy_q     <= 1'b0;
      seen_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cfg_we_q <= acc & (ioctl_addr < 23'(REGSIZE));
      if (acc & (ioctl_addr < 23'(REGSIZE))) begin
        cfg_addr_q <= ioctl_addr[4:0];
        cfg_data_q <= ioctl_data;
      end
      busy_q <= busy;
      if (downloading) seen_q <= 1'b1;
      done_q <= busy_q & ~busy & seen_q;
    end
  end

`ifdef JTCPS1_DWNLD_CHKSUM_EN
  logic [15:0] chk_q;

  always_ff @(posedge clk) begin
    if (rst) chk_q <= '0;
    else     chk_q <= (dl_rise ? 16'h0000 : chk_q) + (acc ? {8'h00, ioctl_data} : 16'h0000);
  end

  assign chksum = chk_q;
`endif

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = prog_we_q;
  assign cfg_we     = cfg_we_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_data   = cfg_data_q;
  assign dwnld_busy = busy;
  assign dwnld_done = done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_jtcps1_dwnld_ctrl.sv
module tb_jtcps1_dwnld_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [22:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_rdy = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        dwnld_busy;
  logic        dwnld_done;
  logic        ovf;
`ifdef JTCPS1_DWNLD_CHKSUM_EN
  logic [15:0] chksum;
`endif

  jtcps1_dwnld_ctrl #(.REGSIZE(21), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rdy(prog_rdy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dwnld_busy(dwnld_busy), .dwnld_done(dwnld_done), .ovf(ovf)
`ifdef JTCPS1_DWNLD_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  m;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  int  done_cnt = 0;
  int  cfg_cnt = 0;
  int  acks = 0;
  bit  rdy_en = 1'b1;
  int  lat_min = 0;
  int  lat_max = 0;

  // Reference model: expected SDRAM writes in order, plus a log of all pushes.
  wr_t         exp_q[$];
  wr_t         log_q[$];
  bit          m_held = 1'b0;
  logic [21:0] m_ha = '0;
  logic [7:0]  m_hd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic m_push(input logic [21:0] a, input logic [15:0] d, input logic [1:0] m);
    wr_t w;
    w = {a, d, m};
    exp_q.push_back(w);
    log_q.push_back(w);
  endtask

  task automatic m_byte(input logic [22:0] addr, input logic [7:0] data);
    logic [21:0] w;
    w = addr[22:1];
    if (!addr[0]) begin
      if (m_held) m_push(m_ha, {8'h00, m_hd}, 2'b10);
      m_held = 1'b1;
      m_ha = w;
      m_hd = data;
    end else if (m_held && m_ha == w) begin
      m_push(w, {data, m_hd}, 2'b00);
      m_held = 1'b0;
    end else begin
      if (m_held) m_push(m_ha, {8'h00, m_hd}, 2'b10);
      m_held = 1'b0;
      m_push(w, {data, 8'h00}, 2'b01);
    end
  endtask

  task automatic m_fall();
    if (m_held) m_push(m_ha, {8'h00, m_hd}, 2'b10);
    m_held = 1'b0;
  endtask

  task automatic set_dl(input logic v);
    @(negedge clk);
    if (downloading && !v) m_fall();
    downloading = v;
  endtask

  task automatic send(input logic [22:0] a, input logic [7:0] d, input int gap);
    bit want;
    @(negedge clk);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    want = downloading && (a < 23'd21);
    if (downloading) m_byte(a, d);
    @(posedge clk);
    #1;
    ioctl_wr = 1'b0;
    chk("cfg_we", cfg_we, want);
    if (want) begin
      chk("cfg_addr", cfg_addr, a[4:0]);
      chk("cfg_data", cfg_data, d);
    end
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!dwnld_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_within_budget", ok, 1'b1);
    chk("all_writes_seen", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // SDRAM responder: acks each request after a latency, checks the acked word
  // against the model and checks that a pending request holds steady.
  initial begin
    int  cnt;
    bit  prev_we;
    bit  prev_ack;
    wr_t prev;
    cnt = -1;
    prev_we = 1'b0;
    prev_ack = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      prog_rdy = 1'b0;
      if (prog_we && prev_we && !prev_ack)
        chk("prog_hold", {prog_addr, prog_data, prog_mask}, prev);
      prev     = {prog_addr, prog_data, prog_mask};
      prev_we  = prog_we;
      prev_ack = 1'b0;
      if (rst || !prog_we || !rdy_en) begin
        cnt = -1;
      end else begin
        if (cnt < 0) cnt = $urandom_range(lat_max, lat_min);
        if (cnt == 0) begin
          prog_rdy = 1'b1;
          prev_ack = 1'b1;
          cnt = -1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%h required=none",
                     {prog_addr, prog_data, prog_mask});
          end else begin
            chk("write", {prog_addr, prog_data, prog_mask}, exp_q[0]);
            void'(exp_q.pop_front());
            acks++;
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (dwnld_done) done_cnt++;
      if (cfg_we) cfg_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0, a0, c0, we_seen;
    logic [22:0] a;
    int          r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prog_we", prog_we, 1'b0);
    chk("rst_prog_addr", prog_addr, 22'd0);
    chk("rst_prog_data", prog_data, 16'd0);
    chk("rst_prog_mask", prog_mask, 2'd0);
    chk("rst_cfg_we", cfg_we, 1'b0);
    chk("rst_cfg_addr", cfg_addr, 5'd0);
    chk("rst_cfg_data", cfg_data, 8'd0);
    chk("rst_busy", dwnld_busy, 1'b0);
    chk("rst_done", dwnld_done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Bytes outside the download window are ignored
    send(23'd3, 8'h77, 3);
    chk("ignored_busy", dwnld_busy, 1'b0);
    chk("ignored_no_model_push", exp_q.size(), 0);

    // Test 1: one paired word, fixed latency, push-to-request latency
    lat_min = 2; lat_max = 2;
    log_q.delete();
    a0 = acks;
    set_dl(1'b1);
    send(23'd0, 8'h11, 4);
    @(negedge clk);
    ioctl_addr = 23'd1; ioctl_data = 8'h22; ioctl_wr = 1'b1;
    m_byte(23'd1, 8'h22);
    chk("t1_model", log_q[0], {22'd0, 16'h2211, 2'b00});
    @(posedge clk);
    #1;
    ioctl_wr = 1'b0;
    chk("t1_cfg", {cfg_we, cfg_addr, cfg_data}, {1'b1, 5'd1, 8'h22});
    chk("t1_we_n1", prog_we, 1'b0);
    @(posedge clk);
    #1;
    chk("t1_we_n2", prog_we, 1'b1);
    chk("t1_data", prog_data, 16'h2211);
    d0 = done_cnt;
    set_dl(1'b0);
    wait_idle();
    chk("t1_writes", acks - a0, 1);
    chk("t1_done", done_cnt - d0, 1);

    // Test 2: flushed even byte then unpaired odd byte
    lat_min = 0; lat_max = 3;
    log_q.delete();
    set_dl(1'b1);
    send(23'd4, 8'hAA, 4);
    send(23'd9, 8'hBB, 4);
    chk("t2_model_n", log_q.size(), 2);
    chk("t2_model_0", log_q[0], {22'd2, 16'h00AA, 2'b10});
    chk("t2_model_1", log_q[1], {22'd4, 16'hBB00, 2'b01});
    set_dl(1'b0);
    wait_idle();

    // Test 3: overflow with acknowledges held off
    rdy_en = 1'b0;
    log_q.delete();
    a0 = acks;
    set_dl(1'b1);
    for (int i = 0; i < 12; i++) send(23'(i), 8'(8'h30 + i), 3);
    repeat (3) @(negedge clk);
    chk("t3_we", prog_we, 1'b1);
    chk("t3_head", {prog_addr, prog_data, prog_mask}, {22'd0, 16'h3130, 2'b00});
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_model_n", log_q.size(), 6);
    exp_q.delete(5);
    exp_q.delete(4);
    rdy_en = 1'b1;
    set_dl(1'b0);
    wait_idle();
    chk("t3_writes", acks - a0, 4);
    chk("t3_ovf_sticky", ovf, 1'b1);
    set_dl(1'b1);
    @(posedge clk);
    #1;
    chk("t3_ovf_clear", ovf, 1'b0);
    set_dl(1'b0);
    wait_idle();

    // Test 4: config strobes over addresses 0..24
    lat_min = 0; lat_max = 2;
    log_q.delete();
    a0 = acks;
    c0 = cfg_cnt;
    set_dl(1'b1);
    for (int i = 0; i < 25; i++) send(23'(i), 8'(i) ^ 8'h5A, 6);
    set_dl(1'b0);
    wait_idle();
    chk("t4_cfg_count", cfg_cnt - c0, 21);
    chk("t4_model_n", log_q.size(), 13);
    chk("t4_writes", acks - a0, 13);

    // Test 5: reset with queued writes
    rdy_en = 1'b0;
    set_dl(1'b1);
    for (int i = 0; i < 6; i++) send(23'(i), 8'(8'hC0 + i), 3);
    set_dl(1'b0);
    repeat (3) @(negedge clk);
    chk("t5_we_before", prog_we, 1'b1);
    chk("t5_queued", exp_q.size(), 3);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_we_rst", prog_we, 1'b0);
    chk("t5_busy_rst", dwnld_busy, 1'b0);
    exp_q.delete();
    m_held = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rdy_en = 1'b1;
    we_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (prog_we) we_seen++;
    end
    chk("t5_no_writes", we_seen, 0);
    chk("t5_no_done", done_cnt - d0, 0);

    // Randomized download
    lat_min = 0; lat_max = 3;
    d0 = done_cnt;
    set_dl(1'b1);
    a = 23'd0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(9, 0);
      if (r < 6)      a = a + 23'd1;
      else if (r < 8) a = 23'($urandom_range(63, 0));
      else            a = a + 23'd2;
      send(a, 8'($urandom), $urandom_range(10, 6));
      if (i == 30) begin
        set_dl(1'b0);
        set_dl(1'b1);
      end
    end
    set_dl(1'b0);
    wait_idle();
    chk("rand_ovf", ovf, 1'b0);
    chk("rand_done", (done_cnt - d0) >= 1, 1'b1);

`ifdef JTCPS1_DWNLD_CHKSUM_EN
    // Test 6: checksum
    set_dl(1'b1);
    send(23'd0, 8'hFF, 3);
    send(23'd1, 8'hFF, 3);
    send(23'd2, 8'h03, 3);
    chk("t6_chksum", chksum, 16'h0201);
    set_dl(1'b0);
    wait_idle();
    set_dl(1'b1);
    @(posedge clk);
    #1;
    chk("t6_chksum_clear", chksum, 16'h0000);
    set_dl(1'b0);
    wait_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
